// File: rtl/bsg_gateway_tag_packet_decoder.sv
// Bit-serial bsg_tag receiver: frames start/id/dnr/len/payload packets and detects the tag reset run.
// Define BSG_GATEWAY_TAG_DECODER_2DEEP_EN to use a 2-entry output FIFO instead of a single register.
module bsg_gateway_tag_packet_decoder #(
  parameter int lg_els_p            = 7,
  parameter int lg_width_p          = 4,
  parameter int max_payload_width_p = 15,
  parameter int reset_len_p         = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           en_i,
  input  logic                           data_i,
  output logic                           v_o,
  input  logic                           ready_i,
  output logic [lg_els_p-1:0]            node_id_o,
  output logic                           data_not_reset_o,
  output logic [lg_width_p-1:0]          len_o,
  output logic [max_payload_width_p-1:0] payload_o,
  output logic                           trunc_o,
  output logic                           overrun_o,
  output logic                           in_reset_o
);

  localparam int max_field_lp = (lg_els_p > (1 << lg_width_p)) ? lg_els_p : (1 << lg_width_p);
  localparam int cnt_w_lp     = $clog2(max_field_lp + 1);
  localparam int ones_w_lp    = $clog2(reset_len_p + 1);
  localparam int pkt_w_lp     = lg_els_p + 1 + lg_width_p + max_payload_width_p + 1;
`ifdef BSG_GATEWAY_TAG_DECODER_2DEEP_EN
  localparam int depth_lp     = 2;
`else
  localparam int depth_lp     = 1;
`endif
  localparam int fcnt_w_lp    = $clog2(depth_lp + 1);

  localparam logic [ones_w_lp-1:0]  ones_max_lp = ones_w_lp'(reset_len_p);
  localparam logic [lg_width_p-1:0] max_len_lp  = lg_width_p'(max_payload_width_p);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID      = 3'd1,
    DNR     = 3'd2,
    LEN     = 3'd3,
    PAYLOAD = 3'd4,
    RST     = 3'd5
  } state_e;

  state_e                         state_q, state_d;
  logic [cnt_w_lp-1:0]            cnt_q, cnt_d, cnt_inc;
  logic [ones_w_lp-1:0]           ones_q, ones_d;
  logic [lg_els_p-1:0]            node_q, node_d;
  logic                           dnr_q, dnr_d;
  logic [lg_width_p-1:0]          len_q, len_d;
  logic [max_payload_width_p-1:0] pay_q, pay_d;
  logic                           complete;
  logic [pkt_w_lp-1:0]            pkt;

  logic [pkt_w_lp-1:0]            mem_q [depth_lp];
  logic [pkt_w_lp-1:0]            mem_d [depth_lp];
  logic [fcnt_w_lp-1:0]           fcnt_q, fcnt_d;
  logic                           overrun_q, overrun_d;
  logic                           deq, enq;

  assign cnt_inc = cnt_q + cnt_w_lp'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ones_d   = ones_q;
    node_d   = node_q;
    dnr_d    = dnr_q;
    len_d    = len_q;
    pay_d    = pay_q;
    complete = 1'b0;
    if (en_i) begin
      if (data_i) begin
        ones_d = (ones_q == ones_max_lp) ? ones_q : ones_q + ones_w_lp'(1);
      end else begin
        ones_d = '0;
      end
      // A full run of ones overrides whatever field is in progress, even a final bit.
      if (data_i && (ones_d == ones_max_lp)) begin
        state_d = RST;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (data_i) begin
              state_d = ID;
              cnt_d   = '0;
              node_d  = '0;
              dnr_d   = 1'b0;
              len_d   = '0;
              pay_d   = '0;
            end
          end
          ID: begin
            for (int i = 0; i < lg_els_p; i++) begin
              if (cnt_q == cnt_w_lp'(i)) node_d[i] = data_i;
            end
            if (cnt_inc == cnt_w_lp'(lg_els_p)) begin
              state_d = DNR;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          DNR: begin
            dnr_d   = data_i;
            state_d = LEN;
            cnt_d   = '0;
          end
          LEN: begin
            for (int i = 0; i < lg_width_p; i++) begin
              if (cnt_q == cnt_w_lp'(i)) len_d[i] = data_i;
            end
            if (cnt_inc == cnt_w_lp'(lg_width_p)) begin
              cnt_d = '0;
              if (len_d == '0) begin
                complete = 1'b1;
                state_d  = IDLE;
              end else begin
                state_d = PAYLOAD;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
          PAYLOAD: begin
            // Bits past the stored width match no index and are simply consumed.
            for (int i = 0; i < max_payload_width_p; i++) begin
              if (cnt_q == cnt_w_lp'(i)) pay_d[i] = data_i;
            end
            if (cnt_inc == cnt_w_lp'(len_q)) begin
              complete = 1'b1;
              state_d  = IDLE;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          RST: begin
            if (!data_i) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign pkt = {node_d, dnr_d, len_d, pay_d, (len_d > max_len_lp)};

  // Shift FIFO: head is always entry 0, so outputs come straight from a register.
  always_comb begin
    deq       = (fcnt_q != '0) && ready_i;
    enq       = complete && ((fcnt_q != fcnt_w_lp'(depth_lp)) || deq);
    overrun_d = overrun_q | (complete & ~enq);
    fcnt_d    = fcnt_q;
    for (int i = 0; i < depth_lp; i++) mem_d[i] = mem_q[i];
    if (deq) begin
      for (int i = 0; i < depth_lp - 1; i++) mem_d[i] = mem_q[i+1];
      fcnt_d = fcnt_q - fcnt_w_lp'(1);
    end
    if (enq) begin
      for (int i = 0; i < depth_lp; i++) begin
        if (fcnt_d == fcnt_w_lp'(i)) mem_d[i] = pkt;
      end
      fcnt_d = fcnt_d + fcnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ones_q    <= '0;
      node_q    <= '0;
      dnr_q     <= 1'b0;
      len_q     <= '0;
      pay_q     <= '0;
      fcnt_q    <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < depth_lp; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      node_q    <= node_d;
      dnr_q     <= dnr_d;
      len_q     <= len_d;
      pay_q     <= pay_d;
      fcnt_q    <= fcnt_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < depth_lp; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign v_o        = (fcnt_q != '0);
  assign {node_id_o, data_not_reset_o, len_o, payload_o, trunc_o} = mem_q[0];
  assign overrun_o  = overrun_q;
  assign in_reset_o = (state_q == RST);

endmodule

// File: doc/bsg_gateway_tag_packet_decoder.md
# bsg_gateway_tag_packet_decoder

Serial-to-parallel decoder for the bsg_tag bit-serial protocol. It is the receive end of the tag stream that the gateway's trace replay drives onto the tag clk/data/en pads. The block samples tag data on the tag clock, frames packets (start bit, node id, data_not_reset, length, payload), detects the tag reset sequence, and presents each complete packet on a valid/ready output. It is used in the gateway testbench to check the tag programming the chip receives, and on-chip as a tag monitor.

## Interface
- lg_els_p, 7: width of the node id field.
- lg_width_p, 4: width of the length field.
- max_payload_width_p, 15: stored payload bits; must be ≤ 2^lg_width_p-1.
- reset_len_p, 32: consecutive sampled ones that signal tag reset; must exceed 1+lg_els_p+1+lg_width_p+2^lg_width_p-1.
- clk_i  in  1  tag clock; all state on posedge.
- reset_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  bit-qualifier; data_i is sampled only when en_i=1.
- data_i  in  1  serial tag data.
- v_o  out  1  packet valid.
- ready_i  in  1  consumer ready; transfer when v_o&ready_i.
- node_id_o  out  lg_els_p  decoded node id.
- data_not_reset_o  out  1  decoded data_not_reset bit.
- len_o  out  lg_width_p  received length field.
- payload_o  out  max_payload_width_p  payload, zero-extended.
- trunc_o  out  1  with v_o: len_o > max_payload_width_p, so excess bits were discarded.
- overrun_o  out  1  sticky: a completed packet was dropped because the output was full.
- in_reset_o  out  1  tag reset sequence detected and still in progress.

## Operation
- A "bit" is a posedge with en_i=1. Cycles with en_i=0 hold all state, including the ones counter.
- Every field is LSB first.
- FSM states: IDLE, ID, DNR, LEN, PAYLOAD, RST.
  - IDLE: bit 0 stays in IDLE; bit 1 (start) goes to ID.
  - ID: lg_els_p bits, then DNR.
  - DNR: 1 bit, then LEN.
  - LEN: lg_width_p bits. If the length is 0, the packet completes on the last LEN bit. Otherwise go to PAYLOAD.
  - PAYLOAD: len bits. Bit k (k<max_payload_width_p) is stored at payload[k]. Bits k≥max_payload_width_p are consumed and discarded. The packet completes on the last bit, then goes to IDLE.
- Packet complete: bit counter equals the field length. The counter is wide enough for max(lg_els_p, 2^lg_width_p) and clears on every field change.
- Ones counter:
  - Increments on each 1 bit in any state and clears on each 0 bit.
  - Saturates at reset_len_p.
  - On reaching reset_len_p: the current partial packet is discarded, the FSM goes to RST, and in_reset_o=1.
  - In RST, the first 0 bit goes to IDLE and clears in_reset_o.
- Output register holds one packet.
  - On completion with the register empty, or with v_o&ready_i in the same cycle, the register loads the new packet.
  - On completion while v_o=1 and ready_i=0, the new packet is dropped and overrun_o is set. overrun_o clears only on reset.
- Reset (any time, including mid-packet): state IDLE; v_o, node_id_o, data_not_reset_o, len_o, payload_o, trunc_o, overrun_o, in_reset_o all 0; counters 0.

## Timing
- v_o rises on the posedge after the clock edge that samples the final bit, so latency is 1 cycle.
- All outputs are registered; there are no combinational paths from input to output.
- Output fields are stable while v_o=1 and ready_i=0.
- v_o falls the cycle after a transfer unless a new packet loads in the same cycle.
- in_reset_o rises the cycle after the reset_len_p-th consecutive one is sampled.
- Minimum packet: 1+lg_els_p+1+lg_width_p bits. Back-to-back packets need no idle bits; the start bit may directly follow the last payload bit.

## Configuration
- BSG_GATEWAY_TAG_DECODER_2DEEP_EN defined: the output register is replaced by a 2-entry FIFO.
  - A packet is dropped (overrun_o set) only when both entries are full and no dequeue happens that cycle.
  - Latency is unchanged: 1 cycle into an empty FIFO.
- Not defined: single output register as described in Operation.

## Test plan
- Basic packet: IDLE zeros, then start, node 5, dnr 1, len 3, payload 101b. Required: v_o one cycle after the last bit; node_id_o=5, data_not_reset_o=1, len_o=3, payload_o=5, trunc_o=0.
- Enable gaps: same packet with en_i=0 for 4 cycles between every bit. Required: identical output; toggling data_i during the gaps has no effect.
- Zero length and back-to-back: len=0 for node 2, followed immediately by node 3 len=1 payload 1. Required: two packets, (2,len 0,payload 0) then (3,len 1,payload 1).
- Reset sequence: 32 consecutive ones starting mid-ID-field. Required: no v_o; in_reset_o=1 after the 32nd one; a 0 bit clears it; the next packet decodes correctly.
- Backpressure: ready_i=0 while two packets complete. Required: the first is held unchanged and overrun_o=1. With BSG_GATEWAY_TAG_DECODER_2DEEP_EN, both are delivered in order and overrun_o=0 until a third completes.
- Truncation: max_payload_width_p=8, len=12, payload 0xABC. Required: payload_o=0xBC, len_o=12, trunc_o=1. Asserting reset_n_i=0 mid-payload clears all outputs and returns the FSM to IDLE.
